snn_batch_runner: RTL and testbench
===================================

# snn_batch_runner

Synthesisable batch sequencer that drives the `snn_core` start/done handshake across NUM_SAMPLES input images. It selects each sample's input RAM and pulses `start`, then waits for `done` under a watchdog. It compares `digit` against the expected label and accumulates pass/fail/timeout counts. It sits between the sample-RAM mux and `snn_core`, and replaces bench-side sequencing so on-chip self-test and FPGA bring-up run unattended.

## Interface
- NUM_SAMPLES, 10, samples per batch (>=1)
- DIGIT_W, 4, width of `digit` and label
- TIMEOUT_CYCLES, 60000, max cycles in WAIT before a sample is declared timed out (>=2)
- GAP_CYCLES, 2, idle cycles between samples (>=1)
- SEL_W / CNT_W (derived), $clog2(NUM_SAMPLES) (min 1) / $clog2(NUM_SAMPLES+1)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  start a batch; sampled only in IDLE
- abort  in  1  terminate the batch immediately
- sample_sel  out  SEL_W  index of the current sample; drives the input-RAM mux
- exp_label  in  DIGIT_W  expected label for `sample_sel`, combinational from an external table
- core_start  out  1  one-cycle start pulse to `snn_core`
- core_done  in  1  `snn_core` done; level input, rising edge is significant
- core_digit  in  DIGIT_W  `snn_core` classification result
- core_clr  out  1  one-cycle soft-clear pulse to `snn_core` after a timeout or abort
- busy  out  1  high in every state except IDLE
- batch_done  out  1  one-cycle pulse on normal batch completion
- result_valid  out  1  one-cycle pulse per finished sample
- result_sample  out  SEL_W  sample index for `result_valid`
- result_digit  out  DIGIT_W  captured `core_digit` (0 on timeout)
- result_match  out  1  `core_digit == exp_label`, valid with `result_valid`
- result_timeout  out  1  sample timed out, valid with `result_valid`
- pass_count, fail_count, timeout_count  out  CNT_W each  batch tallies

## Operation
- States: IDLE, START, WAIT, GAP, FINISH.
- IDLE:
  - `go` = 1 clears all counters and `sample_sel`, then goes to START.
  - `go` is ignored in every other state.
- START:
  - `core_start` = 1 for this single cycle.
  - Watchdog timer cleared; next state is WAIT.
- WAIT:
  - Timer increments every cycle.
  - Done event = `core_done` & ~`done_d`, where `done_d` is a register tracking `core_done` (reset 0).
  - On a done event:
    - Capture `core_digit`.
    - Set `result_match` = (`core_digit` == `exp_label`).
    - Increment `pass_count` on a match, otherwise `fail_count`.
    - Go to GAP.
  - When the timer reaches TIMEOUT_CYCLES-1 with no done event:
    - `result_timeout` = 1, `result_digit` = 0, `result_match` = 0.
    - Increment `timeout_count`, pulse `core_clr`.
    - Go to GAP.
  - A done event in the same cycle as timer expiry counts as done, not timeout.
  - `result_valid` pulses in the cycle after the event. `result_*` outputs hold until the next event.
- GAP:
  - Wait GAP_CYCLES cycles.
  - If `sample_sel` == NUM_SAMPLES-1, go to FINISH. Otherwise increment `sample_sel` and go to START.
  - `sample_sel` never wraps within a batch.
- FINISH: `batch_done` = 1 for one cycle, then IDLE.
  - Invariant at `batch_done`: pass + fail + timeout == NUM_SAMPLES.
- Abort:
  - `abort` in any non-IDLE state goes to IDLE on the next edge.
  - Pulses `core_clr` if the state was START or WAIT.
  - No `result_valid` or `batch_done` for the aborted sample; counters hold their partial values.
  - Abort takes priority over a same-cycle done event or timeout.
- Counters and `result_*` outputs hold after the batch until the next accepted `go`.

## Timing
- Reset values:
  - State IDLE; `sample_sel`, timer and all counts 0.
  - All pulse outputs, `busy`, `result_*` and `done_d` 0.
- All outputs are registered or decoded from the state register only. No combinational path from inputs to outputs.
- `go` sampled at edge k: `busy` and `core_start` high during cycle k+1.
- `core_done` rising at edge m: `result_valid` high during cycle m+1; the next `core_start` comes GAP_CYCLES+1 cycles after that.
- Timeout: `core_start` high in cycle s; `result_valid` and `core_clr` high in cycle s+TIMEOUT_CYCLES.
- `rst_n` low mid-batch: immediate asynchronous return to reset values; no `batch_done`.

## Test plan
- Stub core raises `core_done` 100 cycles after each start with `digit` = `sample_sel`; `exp_label` = index, NUM_SAMPLES=10 -> pass_count=10, fail=0, timeout=0; exactly ten `result_valid` pulses with `result_sample` 0..9; one `batch_done`.
- Same stub, but sample 4 returns digit 7 -> fail_count=1, pass_count=9; `result_match`=0 only for `result_sample`=4.
- TIMEOUT_CYCLES=50, stub never responds on sample 3 -> `result_valid` 50 cycles after that `core_start` with `result_timeout`=1; `core_clr` pulses once; timeout_count=1; batch completes with pass=9.
- `core_done` rises on exactly the timer-expiry cycle -> counted as pass; timeout_count=0; no `core_clr`.
- `abort` asserted during WAIT of sample 5 -> IDLE next cycle, `core_clr` pulse, no `batch_done`, pass_count=5; a subsequent `go` clears counts and restarts from sample 0.
- `rst_n` pulled low during GAP of sample 2 -> all outputs 0 immediately; `go` pulses while busy are ignored (sample_sel not reset).

Source files
------------

// File: rtl/snn_batch_runner_if.sv
// Bundle of the batch-runner control, snn_core handshake and result/tally signals.
// master = the runner, slave = the environment (core stub, label table, host).
interface snn_batch_runner_if #(
   parameter int NUM_SAMPLES = 10,
   parameter int DIGIT_W     = 4
);
   localparam int SEL_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
   localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

   logic               go;
   logic               abort;
   logic [SEL_W-1:0]   sample_sel;
   logic [DIGIT_W-1:0] exp_label;
   logic               core_start;
   logic               core_done;
   logic [DIGIT_W-1:0] core_digit;
   logic               core_clr;
   logic               busy;
   logic               batch_done;
   logic               result_valid;
   logic [SEL_W-1:0]   result_sample;
   logic [DIGIT_W-1:0] result_digit;
   logic               result_match;
   logic               result_timeout;
   logic [CNT_W-1:0]   pass_count;
   logic [CNT_W-1:0]   fail_count;
   logic [CNT_W-1:0]   timeout_count;

   modport master (
      input  go, abort, exp_label, core_done, core_digit,
      output sample_sel, core_start, core_clr, busy, batch_done,
             result_valid, result_sample, result_digit, result_match, result_timeout,
             pass_count, fail_count, timeout_count
   );

   modport slave (
      output go, abort, exp_label, core_done, core_digit,
      input  sample_sel, core_start, core_clr, busy, batch_done,
             result_valid, result_sample, result_digit, result_match, result_timeout,
             pass_count, fail_count, timeout_count
   );
endinterface

// File: rtl/snn_batch_runner.sv
// Sequences snn_core over NUM_SAMPLES images with a per-sample watchdog and tallies results.
// Outputs are registered or decoded from state; result lands one cycle after done/timeout.
module snn_batch_runner #(
   parameter int NUM_SAMPLES    = 10,
   parameter int DIGIT_W        = 4,
   parameter int TIMEOUT_CYCLES = 60000,
   parameter int GAP_CYCLES     = 2,
   parameter int SEL_W          = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
   parameter int CNT_W          = $clog2(NUM_SAMPLES + 1)
) (
   input logic                clk,
   input logic                rst_n,
   snn_batch_runner_if.master bus
);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   // Timer starts at 0 in the first WAIT cycle; expiring at T-2 puts the
   // registered timeout result exactly TIMEOUT_CYCLES cycles after core_start.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SAMPLES - 1);
   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_GAP, S_FINISH} state_t;

   state_t           state, state_nxt;
   logic             done_d;
   logic [TMR_W-1:0] timer;
   logic [GAP_W-1:0] gap_cnt;
   logic             done_ev, expire, gap_end, last_sample, abort_hit;

   assign done_ev     = bus.core_done & ~done_d;
   assign expire      = (timer == TMR_LAST);
   assign gap_end     = (gap_cnt == GAP_LAST);
   assign last_sample = (bus.sample_sel == SEL_LAST);
   assign abort_hit   = bus.abort && (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.busy       = (state != S_IDLE);
      bus.core_start = (state == S_START);
      bus.batch_done = (state == S_FINISH);
      case (state)
         S_IDLE:   if (bus.go) state_nxt = S_START;
         S_START:  state_nxt = S_WAIT;
         S_WAIT:   if (done_ev || expire) state_nxt = S_GAP;
         S_GAP:    if (gap_end) state_nxt = last_sample ? S_FINISH : S_START;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (abort_hit) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_d             <= 1'b0;
         timer              <= '0;
         gap_cnt            <= '0;
         bus.sample_sel     <= '0;
         bus.core_clr       <= 1'b0;
         bus.result_valid   <= 1'b0;
         bus.result_sample  <= '0;
         bus.result_digit   <= {DIGIT_W{1'b0}};
         bus.result_match   <= 1'b0;
         bus.result_timeout <= 1'b0;
         bus.pass_count     <= '0;
         bus.fail_count     <= '0;
         bus.timeout_count  <= '0;
      end else begin
         done_d           <= bus.core_done;
         bus.result_valid <= 1'b0;
         bus.core_clr     <= 1'b0;
         if (state != S_GAP) gap_cnt <= '0;

         // Abort outranks a same-cycle done or timeout: nothing is reported.
         if (abort_hit) begin
            if (state == S_START || state == S_WAIT) bus.core_clr <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.go) begin
                     bus.sample_sel    <= '0;
                     bus.pass_count    <= '0;
                     bus.fail_count    <= '0;
                     bus.timeout_count <= '0;
                  end
               end
               S_START: timer <= '0;
               S_WAIT: begin
                  if (done_ev) begin
                     bus.result_valid   <= 1'b1;
                     bus.result_sample  <= bus.sample_sel;
                     bus.result_digit   <= bus.core_digit;
                     bus.result_match   <= (bus.core_digit == bus.exp_label);
                     bus.result_timeout <= 1'b0;
                     if (bus.core_digit == bus.exp_label)
                        bus.pass_count <= bus.pass_count + CNT_ONE;
                     else
                        bus.fail_count <= bus.fail_count + CNT_ONE;
                  end else if (expire) begin
                     bus.result_valid   <= 1'b1;
                     bus.result_sample  <= bus.sample_sel;
                     bus.result_digit   <= {DIGIT_W{1'b0}};
                     bus.result_match   <= 1'b0;
                     bus.result_timeout <= 1'b1;
                     bus.timeout_count  <= bus.timeout_count + CNT_ONE;
                     bus.core_clr       <= 1'b1;
                  end else begin
                     timer <= timer + TMR_ONE;
                  end
               end
               S_GAP: begin
                  gap_cnt <= gap_cnt + GAP_ONE;
                  if (gap_end && !last_sample) bus.sample_sel <= bus.sample_sel + SEL_ONE;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_snn_batch_runner.sv
// Bench for snn_batch_runner: a table-driven snn_core stub feeds a result scoreboard
// checked by an independent monitor; directed batches cover pass, fail, timeout, abort, reset.
module tb_snn_batch_runner;
   localparam int NS  = 10;
   localparam int DW  = 4;
   localparam int TO  = 50;
   localparam int GAP = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   snn_batch_runner_if #(.NUM_SAMPLES(NS), .DIGIT_W(DW)) bus ();

   snn_batch_runner #(
      .NUM_SAMPLES(NS), .DIGIT_W(DW), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.master)
   );

   // Expected label for sample i is i.
   assign bus.exp_label = DW'(bus.sample_sel);

   typedef struct {
      int sample;
      int digit;
      int match;
      int tmo;
      int lat;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   start_cyc = 0;
   int   clr_cnt = 0, bd_cnt = 0, res_cnt = 0;

   int resp_delay [NS];
   int resp_digit [NS];
   int resp_never [NS];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard on each result_valid and tallies pulses.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (bus.core_start) start_cyc = cyc;
      if (bus.core_clr) clr_cnt++;
      if (bus.batch_done) begin
         bd_cnt++;
         chk("done_invariant", int'(bus.pass_count) + int'(bus.fail_count) + int'(bus.timeout_count), NS);
      end
      if (bus.result_valid) begin
         res_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("res_sample",  int'(bus.result_sample),  e.sample);
            chk("res_digit",   int'(bus.result_digit),   e.digit);
            chk("res_match",   int'(bus.result_match),   e.match);
            chk("res_timeout", int'(bus.result_timeout), e.tmo);
            chk("res_latency", cyc - start_cyc,          e.lat);
            chk("res_clr",     int'(bus.core_clr),       e.tmo);
         end
      end
   end

   // snn_core stub: answers each start per the response tables, gives up on abort.
   initial begin
      bus.core_done  = 1'b0;
      bus.core_digit = '0;
      forever begin
         @(negedge clk);
         if (bus.core_start) begin
            int  i;
            bit  gone;
            int  n;
            i = int'(bus.sample_sel);
            if (resp_never[i] != 0) begin
               sb.push_back('{i, 0, 0, 1, TO});
            end else begin
               gone = 1'b0;
               n    = 0;
               while (!gone && n < resp_delay[i]) begin
                  @(negedge clk);
                  n++;
                  if (!bus.busy) gone = 1'b1;
               end
               if (!gone) begin
                  bus.core_digit = DW'(resp_digit[i]);
                  bus.core_done  = 1'b1;
                  sb.push_back('{i, resp_digit[i], (resp_digit[i] == i) ? 1 : 0, 0, resp_delay[i] + 1});
                  repeat (2) @(negedge clk);
                  bus.core_done = 1'b0;
               end
            end
         end
      end
   end

   task automatic set_tables();
      for (int i = 0; i < NS; i++) begin
         resp_delay[i] = 20;
         resp_digit[i] = i;
         resp_never[i] = 0;
      end
      clr_cnt = 0;
      bd_cnt  = 0;
      res_cnt = 0;
   endtask

   task automatic pulse_go();
      bus.go = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(bus.busy), 0);
   endtask

   task automatic wait_start(input int s, input string name);
      int n = 0;
      while (!(bus.core_start && int'(bus.sample_sel) == s) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(bus.sample_sel), s);
   endtask

   task automatic check_zero();
      chk("z_busy",    int'(bus.busy),          0);
      chk("z_sel",     int'(bus.sample_sel),    0);
      chk("z_start",   int'(bus.core_start),    0);
      chk("z_clr",     int'(bus.core_clr),      0);
      chk("z_bdone",   int'(bus.batch_done),    0);
      chk("z_rvalid",  int'(bus.result_valid),  0);
      chk("z_rsample", int'(bus.result_sample), 0);
      chk("z_rdigit",  int'(bus.result_digit),  0);
      chk("z_rmatch",  int'(bus.result_match),  0);
      chk("z_rtmo",    int'(bus.result_timeout),0);
      chk("z_pass",    int'(bus.pass_count),    0);
      chk("z_fail",    int'(bus.fail_count),    0);
      chk("z_tmo",     int'(bus.timeout_count), 0);
   endtask

   task automatic check_counts(input string tag, input int p, input int f, input int t,
                               input int bd, input int clr);
      chk({tag, "_pass"},    int'(bus.pass_count),    p);
      chk({tag, "_fail"},    int'(bus.fail_count),    f);
      chk({tag, "_timeout"}, int'(bus.timeout_count), t);
      chk({tag, "_bdone"},   bd_cnt,                  bd);
      chk({tag, "_clr"},     clr_cnt,                 clr);
      chk({tag, "_sb_left"}, sb.size(),               0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst_n     = 1'b0;
      bus.go    = 1'b0;
      bus.abort = 1'b0;
      set_tables();
      repeat (3) @(negedge clk);
      check_zero();
      rst_n = 1'b1;
      @(negedge clk);

      // All samples correct; a go pulse mid-batch must be ignored.
      set_tables();
      pulse_go();
      wait_start(3, "a_reach3");
      repeat (5) @(negedge clk);
      pulse_go();
      chk("a_go_ignored", int'(bus.sample_sel), 3);
      wait_idle("a_finish");
      check_counts("a", 10, 0, 0, 1, 0);
      chk("a_results", res_cnt, 10);

      // Sample 4 misclassified as 7.
      set_tables();
      resp_digit[4] = 7;
      pulse_go();
      wait_idle("b_finish");
      check_counts("b", 9, 1, 0, 1, 0);

      // Sample 3 never answers: watchdog fires.
      set_tables();
      resp_never[3] = 1;
      pulse_go();
      wait_idle("c_finish");
      check_counts("c", 9, 0, 1, 1, 1);

      // Sample 6 answers on the exact expiry cycle: counts as done.
      set_tables();
      resp_delay[6] = TO - 1;
      pulse_go();
      wait_idle("d_finish");
      check_counts("d", 10, 0, 0, 1, 0);

      // Abort during WAIT of sample 5, then restart cleanly.
      set_tables();
      pulse_go();
      wait_start(5, "e_reach5");
      repeat (5) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("e_abort_busy", int'(bus.busy),     0);
      chk("e_abort_clr",  int'(bus.core_clr), 1);
      repeat (3) @(negedge clk);
      check_counts("e", 5, 0, 0, 0, 1);
      pulse_go();
      chk("e2_start", int'(bus.core_start), 1);
      chk("e2_busy",  int'(bus.busy),       1);
      chk("e2_sel",   int'(bus.sample_sel), 0);
      chk("e2_pass",  int'(bus.pass_count), 0);
      wait_idle("e2_finish");
      check_counts("e2", 10, 0, 0, 1, 1);

      // Reset asserted in the GAP after sample 2.
      set_tables();
      pulse_go();
      begin
         int n = 0;
         while (!(bus.result_valid && int'(bus.result_sample) == 2) && n < 2000) begin
            @(negedge clk);
            n++;
         end
         chk("f_reach2", int'(bus.result_sample), 2);
      end
      #2 rst_n = 1'b0;
      #1 check_zero();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("f_idle",  int'(bus.busy), 0);
      chk("f_bdone", bd_cnt,         0);
      chk("f_sb",    sb.size(),      0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
